wb_bus_arbiter: RTL
===================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, giving the number of Wishbone masters (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles a strobe may wait for ack before forced termination (legal range 1..65535).
REQ-003 SHALL use one clock; reset is synchronous and active-low; ports clk and rst_n.
REQ-004 SHALL have ports: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports per master m (arrays indexed 0..NUM_MASTERS-1): m_cyc_i  in  1  cycle; m_stb_i  in  1  strobe; m_we_i  in  1  write; m_addr_i  in  32  address; m_data_i  in  64  write data; m_data_o  out  64  read data; m_ack_o  out  1  ack; m_err_o  out  1  timeout error.
REQ-006 SHALL have slave-side ports toward the peripheral bus: s_cyc_o  out  1; s_stb_o  out  1; s_we_o  out  1; s_addr_o  out  32; s_data_o  out  64; s_data_i  in  64; s_ack_i  in  1.
REQ-007 SHALL have status ports: grant_o  out  NUM_MASTERS  one-hot current owner (zero when idle); busy_o  out  1  bus owned.

Function
REQ-008 SHALL implement a three-state FSM: IDLE, BUSY, ERR.
REQ-009 IDLE: when any m_cyc_i is high, SHALL register a grant to the first requester found searching from last_grant+1 upward, wrapping modulo NUM_MASTERS, and enter BUSY.
REQ-010 Grant latency SHALL be exactly one cycle: s_cyc_o rises in the cycle after the sampled request.
REQ-011 BUSY: s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o SHALL combinationally follow the granted master; s_ack_i and s_data_i SHALL be routed to that master only.
REQ-012 Non-granted masters SHALL see m_ack_o=0, m_err_o=0, m_data_o=0.
REQ-013 Grant SHALL be held, without preemption, until the granted m_cyc_i is low; the FSM then returns to IDLE and last_grant is updated.
REQ-014 Exactly one IDLE cycle (s_cyc_o=0) SHALL separate consecutive grants.
REQ-015 A 16-bit wait counter SHALL clear on grant and on every s_ack_i, and increment each cycle s_stb_o=1 and s_ack_i=0.
REQ-016 When the counter reaches TIMEOUT_CYCLES with s_ack_i low, SHALL pulse m_err_o of the owner for one cycle, force s_cyc_o/s_stb_o to 0, and enter ERR.
REQ-017 If s_ack_i is high in the cycle the counter reaches TIMEOUT_CYCLES, the ack SHALL win: no error, counter cleared.
REQ-018 ERR: s_cyc_o=0; SHALL remain until the owner drops m_cyc_i, then go to IDLE with last_grant updated.
REQ-019 If the owner drops m_cyc_i while s_ack_i is high, the ack SHALL still be delivered that cycle.
REQ-020 busy_o SHALL be 1 in BUSY and ERR, 0 in IDLE.

Reset
REQ-021 When rst_n=0 at a clock edge, SHALL enter IDLE, clear counter and grant, set last_grant to NUM_MASTERS-1 (master 0 has first priority).
REQ-022 During and after reset, all outputs SHALL be 0 until a new grant, including when reset interrupts a transaction in BUSY or ERR.

Structure
REQ-023 The state enum, wait-counter width and TIMEOUT default SHALL reside in shared package wb_arb_pkg.
REQ-024 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs request vector and last_grant; outputs one-hot grant and valid).

Verification
REQ-025 After reset, m0 and m1 request simultaneously -> m0 granted; after m0 drops cyc, one idle cycle, then m1 granted.
REQ-026 m1 holds cyc for 4 back-to-back strobes while m0 requests -> no preemption; m0 granted exactly 2 cycles after m1 drops cyc.
REQ-027 Slave never acks with TIMEOUT_CYCLES=8 -> m_err_o pulses on the 8th waiting cycle and s_cyc_o falls the same cycle.
REQ-028 Slave acks exactly in the timeout cycle -> m_ack_o=1 and m_err_o=0.
REQ-029 m0 reads with s_data_i=64'hDEAD_BEEF_0123_4567 -> m0 receives the data with ack; m1 sees m_data_o=0 and m_ack_o=0.
REQ-030 rst_n=0 in BUSY -> next cycle all outputs 0; first post-reset grant goes to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone bus arbiter.
package wb_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } arb_state_e;

  localparam int WAIT_W          = 16;
  localparam int TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after last_i, wrapping.
module rr_pick #(
  parameter int N    = 2,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] last_i,
  output logic [N-1:0]    gnt_o,
  output logic            vld_o
);
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!vld_o && req_i[j] && (j == (int'(last_i) + k) % N)) begin
          gnt_o[j] = 1'b1;
          vld_o    = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/wb_bus_arbiter.sv
// N-master to one-slave Wishbone arbiter: round-robin grant, no preemption,
// per-strobe ack timeout that aborts the cycle and flags the owner.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_MASTERS-1:0]       m_cyc_i,
  input  logic [NUM_MASTERS-1:0]       m_stb_i,
  input  logic [NUM_MASTERS-1:0]       m_we_i,
  input  logic [NUM_MASTERS-1:0][31:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0][63:0] m_data_i,
  output logic [NUM_MASTERS-1:0][63:0] m_data_o,
  output logic [NUM_MASTERS-1:0]       m_ack_o,
  output logic [NUM_MASTERS-1:0]       m_err_o,
  output logic                         s_cyc_o,
  output logic                         s_stb_o,
  output logic                         s_we_o,
  output logic [31:0]                  s_addr_o,
  output logic [63:0]                  s_data_o,
  input  logic [63:0]                  s_data_i,
  input  logic                         s_ack_i,
  output logic [NUM_MASTERS-1:0]       grant_o,
  output logic                         busy_o
);
  localparam int IDXW = $clog2(NUM_MASTERS);
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDXW-1:0]        last_q, last_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic                   pick_vld;
  logic                   own_cyc, own_stb, own_we;
  logic [31:0]            own_addr;
  logic [63:0]            own_data;
  logic [IDXW-1:0]        own_idx;
  logic                   timeout;
  logic                   drive;

  rr_pick #(.N(NUM_MASTERS), .IDXW(IDXW)) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  always_comb begin
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_addr = '0;
    own_data = '0;
    own_idx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        own_cyc  = m_cyc_i[i];
        own_stb  = m_stb_i[i];
        own_we   = m_we_i[i];
        own_addr = m_addr_i[i];
        own_data = m_data_i[i];
        own_idx  = IDXW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_gnt;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!own_cyc) begin
          grant_d = '0;
          last_d  = own_idx;
          state_d = ST_IDLE;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (own_stb) begin
          // this cycle is the TIMEOUT_CYCLES-th without ack: abort now
          if (cnt_q == TO_LAST) begin
            timeout = 1'b1;
            cnt_d   = '0;
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (!own_cyc) begin
          grant_d = '0;
          last_d  = own_idx;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDXW'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // rst_n gating keeps outputs quiet even in the cycle reset is asserted
  assign drive    = rst_n && (state_q == ST_BUSY) && !timeout;
  assign s_cyc_o  = drive && own_cyc;
  assign s_stb_o  = drive && own_stb;
  assign s_we_o   = drive && own_we;
  assign s_addr_o = drive ? own_addr : '0;
  assign s_data_o = drive ? own_data : '0;
  assign busy_o   = rst_n && (state_q != ST_IDLE);
  assign grant_o  = rst_n ? grant_q : '0;

  always_comb begin
    m_data_o = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rst_n && grant_q[i] && (state_q == ST_BUSY)) begin
        m_data_o[i] = s_data_i;
        m_ack_o[i]  = s_ack_i;
        m_err_o[i]  = timeout;
      end
    end
  end
endmodule
